// File: rtl/iter_linear_calc_arb.sv
// Round-robin arbiter in front of one shared shift-free iterative engine computing y = m*x + b.
// The product is formed by adding m to an accumulator x times, one addition per clock.
module iter_linear_calc_arb #(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] m_flat,
  input  logic [NREQ*W-1:0] x_flat,
  input  logic [NREQ*W-1:0] b_flat,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      y,
  output logic              y_valid,
  output logic [2:0]        y_id,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [NREQ-1:0] ACK_ONE  = NREQ'(1);
  localparam logic [2:0]      LAST_ID  = 3'(NREQ - 1);

  logic [1:0]      r_state;
  logic [2:0]      r_ptr;
  logic [2:0]      r_id;
  logic [W-1:0]    r_m;
  logic [W-1:0]    r_x;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_cnt;
  logic [NREQ-1:0] r_ack;
  logic [W-1:0]    r_y;
  logic            r_y_valid;
  logic [2:0]      r_y_id;

  logic [NREQ-1:0] w_elig;
  logic            w_grant_valid;
  logic [2:0]      w_grant_id;
  int              w_idx;
  logic [W-1:0]    w_sel_m;
  logic [W-1:0]    w_sel_x;
  logic [W-1:0]    w_sel_b;

  // The requester being acked this cycle may still hold req; mask it so it is not served twice.
  assign w_elig = req & ~r_ack;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    w_grant_valid = 1'b0;
    w_grant_id    = '0;
    w_idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_grant_valid && w_elig[w_idx]) begin
        w_grant_valid = 1'b1;
        w_grant_id    = 3'(w_idx);
      end
    end
  end

  assign w_sel_m = m_flat[int'(w_grant_id)*W +: W];
  assign w_sel_x = x_flat[int'(w_grant_id)*W +: W];
  assign w_sel_b = b_flat[int'(w_grant_id)*W +: W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_m       <= '0;
      r_x       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ack     <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_y_id    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      r_ack     <= '0;
      r_y_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_valid) begin
            r_id    <= w_grant_id;
            r_m     <= w_sel_m;
            r_x     <= w_sel_x;
            r_b     <= w_sel_b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= (w_sel_x == '0) ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          r_acc <= r_acc + r_m;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == r_x - 1'b1) r_state <= S_DONE;
        end
        S_DONE: begin
          r_y       <= r_acc + r_b;
          r_ack     <= ACK_ONE << r_id;
          r_y_valid <= 1'b1;
          r_y_id    <= r_id;
          r_ptr     <= (r_id == LAST_ID) ? 3'd0 : r_id + 3'd1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack     = r_ack;
  assign y       = r_y;
  assign y_valid = r_y_valid;
  assign y_id    = r_y_id;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_iter_linear_calc_arb.sv
// Directed bench for iter_linear_calc_arb: single-requester vectors, reset abort,
// round-robin order with all requests held, and operand changes during calculation.
module tb_iter_linear_calc_arb;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] m_flat;
  logic [NREQ*W-1:0] x_flat;
  logic [NREQ*W-1:0] b_flat;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      y;
  logic              y_valid;
  logic [2:0]        y_id;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  iter_linear_calc_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .m_flat  (m_flat),
    .x_flat  (x_flat),
    .b_flat  (b_flat),
    .ack     (ack),
    .y       (y),
    .y_valid (y_valid),
    .y_id    (y_id),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] m;
    logic [31:0] x;
    logic [31:0] b;
    logic [31:0] exp_y;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_op(input int id, input logic [31:0] m, input logic [31:0] x,
                        input logic [31:0] b);
    m_flat[id*W +: W] = m;
    x_flat[id*W +: W] = x;
    b_flat[id*W +: W] = b;
  endtask

  // Counts edges (first counted edge = grant edge) until ack appears, bounded.
  task automatic wait_ack(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (ack == '0 && cycles < 200);
  endtask

  initial begin
    int          cyc;
    int          n_ack;
    int          first_cyc;
    logic [31:0] first_y;
    logic [2:0]  first_id;
    int          exp_order[5];
    logic [31:0] exp_rr_y[5];

    vecs[0] = '{id: 0, m: 32'd3,          x: 32'd5,  b: 32'd7,          exp_y: 32'd22,         exp_lat: 7};
    vecs[1] = '{id: 1, m: 32'd9,          x: 32'd0,  b: 32'd4,          exp_y: 32'd4,          exp_lat: 2};
    vecs[2] = '{id: 2, m: 32'hFFFF_FFFF,  x: 32'd2,  b: 32'd3,          exp_y: 32'h0000_0001,  exp_lat: 4};
    vecs[3] = '{id: 3, m: 32'd100,        x: 32'd10, b: 32'd5,          exp_y: 32'd1005,       exp_lat: 12};
    vecs[4] = '{id: 0, m: 32'd0,          x: 32'd3,  b: 32'hDEAD_BEEF,  exp_y: 32'hDEAD_BEEF,  exp_lat: 5};
    vecs[5] = '{id: 2, m: 32'd7,          x: 32'd1,  b: 32'd0,          exp_y: 32'd7,          exp_lat: 3};

    rst_n  = 1'b0;
    req    = '0;
    m_flat = '0;
    x_flat = '0;
    b_flat = '0;
    #2;
    check("reset_ack",     64'(ack),     64'h0);
    check("reset_y",       64'(y),       64'h0);
    check("reset_y_valid", 64'(y_valid), 64'h0);
    check("reset_y_id",    64'(y_id),    64'h0);
    check("reset_busy",    64'(busy),    64'h0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-requester vectors from idle.
    for (int i = 0; i < 6; i++) begin
      set_op(vecs[i].id, vecs[i].m, vecs[i].x, vecs[i].b);
      req = NREQ'(1) << vecs[i].id;
      wait_ack(cyc);
      check($sformatf("v%0d_latency", i), 64'(cyc),     64'(vecs[i].exp_lat));
      check($sformatf("v%0d_ack", i),     64'(ack),     64'(NREQ'(1) << vecs[i].id));
      check($sformatf("v%0d_y", i),       64'(y),       64'(vecs[i].exp_y));
      check($sformatf("v%0d_y_id", i),    64'(y_id),    64'(vecs[i].id));
      check($sformatf("v%0d_y_valid", i), 64'(y_valid), 64'h1);
      check($sformatf("v%0d_busy", i),    64'(busy),    64'h0);
      req = '0;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_ack_pulse", i), 64'(ack),     64'h0);
      check($sformatf("v%0d_valid_pulse", i), 64'(y_valid), 64'h0);
      check($sformatf("v%0d_y_hold", i),    64'(y),       64'(vecs[i].exp_y));
    end

    // Reset during the calculation of requester 2.
    set_op(2, 32'd5, 32'd10, 32'd0);
    req = 4'b0100;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_before", 64'(busy), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ack",     64'(ack),     64'h0);
    check("abort_y",       64'(y),       64'h0);
    check("abort_y_valid", 64'(y_valid), 64'h0);
    check("abort_busy",    64'(busy),    64'h0);

    // All requests held: order 0,1,2,3,0, one ack every 4 cycles.
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 1), 32'd2, 32'(10 * i));
    exp_order = '{0, 1, 2, 3, 0};
    exp_rr_y  = '{32'd2, 32'd14, 32'd26, 32'd38, 32'd2};
    req = 4'b1111;
    @(posedge clk);
    #3 rst_n = 1'b1;
    cyc   = 0;
    n_ack = 0;
    while (n_ack < 5 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ack != '0) begin
        check($sformatf("rr%0d_ack", n_ack),   64'(ack),  64'(NREQ'(1) << exp_order[n_ack]));
        check($sformatf("rr%0d_y_id", n_ack),  64'(y_id), 64'(exp_order[n_ack]));
        check($sformatf("rr%0d_y", n_ack),     64'(y),    64'(exp_rr_y[n_ack]));
        check($sformatf("rr%0d_cycle", n_ack), 64'(cyc),  64'(4 * (n_ack + 1)));
        n_ack++;
        if (n_ack == 5) req = '0;
      end
    end
    check("rr_ack_count", 64'(n_ack), 64'd5);
    n_ack = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ack != '0) n_ack++;
    end
    check("rr_no_extra_ack", 64'(n_ack), 64'd0);
    check("rr_idle_busy",    64'(busy),  64'h0);

    // Requester 0 changes its operands and drops req during the calculation.
    set_op(0, 32'd5, 32'd4, 32'd1);
    req       = 4'b0001;
    cyc       = 0;
    n_ack     = 0;
    first_cyc = 0;
    first_y   = '0;
    first_id  = '0;
    while (cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 2) begin
        set_op(0, 32'd100, 32'd1, 32'd0);
        req = '0;
      end
      if (ack != '0) begin
        n_ack++;
        if (n_ack == 1) begin
          first_cyc = cyc;
          first_y   = y;
          first_id  = y_id;
          check("chg_ack", 64'(ack), 64'h1);
        end
      end
    end
    check("chg_ack_count", 64'(n_ack),     64'd1);
    check("chg_latency",   64'(first_cyc), 64'd6);
    check("chg_y",         64'(first_y),   64'd21);
    check("chg_y_id",      64'(first_id),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_linear_calc_arb.md
ITER_LINEAR_CALC_ARB -- requirements
Module: iter_linear_calc_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter W, default 32, operand/result width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous reset, active-low.
REQ-005 SHALL have port req  input  NREQ  per-requester request, level, held until ack.
REQ-006 SHALL have port m_flat  input  NREQ*W  slope of requester i at bits [i*W +: W].
REQ-007 SHALL have port x_flat  input  NREQ*W  abscissa of requester i, unsigned iteration count.
REQ-008 SHALL have port b_flat  input  NREQ*W  intercept of requester i.
REQ-009 SHALL have port ack  output  NREQ  one-cycle pulse to the served requester; result valid.
REQ-010 SHALL have port y  output  W  result m*x+b of the served request.
REQ-011 SHALL have port y_valid  output  1  high exactly when any ack bit is high.
REQ-012 SHALL have port y_id  output  3  index of the served requester while y_valid.
REQ-013 SHALL have port busy  output  1  high in states LOAD-excluded CALC and DONE.

Function
REQ-014 SHALL share one multiplier-free iterative engine among NREQ requesters: acc accumulates m once per clock, x times, then y = acc + b.
REQ-015 SHALL implement FSM states S_IDLE, S_CALC, S_DONE; reset state S_IDLE.
REQ-016 In S_IDLE with any eligible req bit set, SHALL grant by round-robin starting at pointer ptr, latch m, x, b, id of the winner, clear acc and cnt, go to S_CALC (x!=0) or S_DONE (x==0).
REQ-017 Eligible req = req AND NOT ack (requester whose ack is high this cycle is masked, preventing double service of a held request).
REQ-018 In S_CALC SHALL do acc <= acc + m_latched, cnt <= cnt + 1; when cnt == x_latched-1 go to S_DONE.
REQ-019 In S_DONE SHALL register y <= acc + b_latched, ack[id] <= 1, y_valid <= 1, y_id <= id, ptr <= (id+1) mod NREQ, go to S_IDLE.
REQ-020 ack, y_valid SHALL be high for exactly one cycle; y and y_id SHALL hold their value until the next S_DONE.
REQ-021 Latency: for grant at edge E0, ack SHALL be high in the cycle after edge E0+x+1 (x=0 gives E0+1).
REQ-022 Operands SHALL be sampled only at grant; changes to m/x/b/req of the served requester during S_CALC SHALL NOT affect the result.
REQ-023 Deassertion of the served requester's req mid-calculation SHALL NOT abort; ack is still issued.
REQ-024 Arithmetic SHALL be unsigned modulo 2^W; overflow wraps silently, no flag.
REQ-025 Round-robin: the most recently served requester SHALL be lowest priority; with all req high, service order SHALL be 0,1,...,NREQ-1,0.
REQ-026 Back-to-back: a new grant SHALL be possible in the S_IDLE cycle concurrent with the previous ack.

Reset
REQ-027 rst_n low SHALL immediately force state S_IDLE, ack=0, y_valid=0, y=0, y_id=0, busy=0, ptr=0, acc=0, cnt=0.
REQ-028 Reset mid-calculation SHALL discard the operation; no ack SHALL be issued for it after release.
REQ-029 After rst_n rises, the first grant SHALL occur no earlier than the first rising clk edge with rst_n high.

Verification
REQ-030 req=0001, m0=3, x0=5, b0=7 -> ack=0001 at E0+6, y=22, y_id=0, then idle.
REQ-031 req=0010, m1=9, x1=0, b1=4 -> ack=0010 at E0+1, y=4; no S_CALC cycles.
REQ-032 req=1111 all held, x=2 each -> acks in order 0,1,2,3,0 spaced 4 cycles, y per requester correct.
REQ-033 m=0xFFFFFFFF, x=2, b=3 -> y=0x00000001 (wrap).
REQ-034 rst_n pulsed low during S_CALC of req 2 -> outputs zero immediately, no ack for req 2, next grant starts from requester 0.
REQ-035 requester 0 changes m0 and drops req during S_CALC -> y computed from latched operands, ack[0] still pulses once.
